// File: rtl/multi_cycle_core.sv
// multi_cycle_core: multi-cycle RV32I/RV32E subset core with one shared ALU and one unified req/ready memory port
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);
  localparam int AW = (NUM_REGS == 16) ? 4 : 5;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  state_t state, state_n;
  logic [31:0] instr, oldpc, aluout, mdr;
  logic [31:0] alu_a, alu_b, alu_y, rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [2:0]  alu_op, f3;
  logic [6:0]  opcode;
  logic [AW-1:0] rs1_i, rs2_i, rd_i;
  logic op_ok, bad_idx, use_rd, use_rs1, use_rs2, tgt_mis, beq_take, beq_retire;
  logic [31:0] regs [NUM_REGS];

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign rd_i   = instr[7 +: AW];
  assign rs1_i  = instr[15 +: AW];
  assign rs2_i  = instr[20 +: AW];
  assign rs1_v  = regs[rs1_i];
  assign rs2_v  = regs[rs2_i];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign op_ok      = f3 == 3'b000 || f3 == 3'b010 || f3[2:1] == 2'b11;
  assign use_rd     = opcode == OP_LW || opcode == OP_R || opcode == OP_I || opcode == OP_JAL;
  assign use_rs1    = opcode == OP_LW || opcode == OP_SW || opcode == OP_R || opcode == OP_I || opcode == OP_B;
  assign use_rs2    = opcode == OP_SW || opcode == OP_R || opcode == OP_B;
  // RV32E has no x16..x31; flag only the fields the format actually uses
  assign bad_idx    = NUM_REGS == 16 && ((use_rd & instr[11]) | (use_rs1 & instr[19]) | (use_rs2 & instr[24]));
  assign tgt_mis    = aluout[1:0] != 2'b00;
  assign beq_take   = alu_y == 32'd0;
  assign beq_retire = f3 == 3'b000 && !(beq_take && tgt_mis);

  // alu_op: 0 add, 1 sub, 2 slt, 6 or, 7 and (matches funct3 except sub)
  always_comb begin
    alu_a  = state == FETCH ? pc : (state == DECODE || state == JAL) ? oldpc : rs1_v;
    alu_b  = (state == FETCH || state == JAL) ? 32'd4 :
             state == DECODE ? (opcode == OP_JAL ? imm_j : imm_b) :
             state == MEMADR ? (opcode == OP_SW ? imm_s : imm_i) :
             state == EXECI  ? imm_i : rs2_v;
    alu_op = state == EXECR ? (f3 == 3'b000 ? {2'b00, instr[30]} : f3) :
             state == EXECI ? f3 : state == BEQ ? 3'd1 : 3'd0;
    alu_y  = alu_op == 3'd1 ? alu_a - alu_b :
             alu_op == 3'd2 ? {31'd0, $signed(alu_a) < $signed(alu_b)} :
             alu_op == 3'd6 ? alu_a | alu_b :
             alu_op == 3'd7 ? alu_a & alu_b : alu_a + alu_b;
  end

  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else     state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      FETCH:    state_n = mem_ready ? DECODE : FETCH;
      DECODE:   state_n = bad_idx ? TRAP :
                          (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                          opcode == OP_R   ? EXECR :
                          opcode == OP_I   ? EXECI :
                          opcode == OP_B   ? BEQ :
                          opcode == OP_JAL ? JAL : TRAP;
      MEMADR:   state_n = alu_y[1:0] != 2'b00 ? TRAP : opcode == OP_SW ? MEMWRITE : MEMREAD;
      MEMREAD:  state_n = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_n = FETCH;
      MEMWRITE: state_n = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_n = op_ok ? ALUWB : TRAP;
      EXECI:    state_n = op_ok ? ALUWB : TRAP;
      ALUWB:    state_n = FETCH;
      BEQ:      state_n = beq_retire ? FETCH : TRAP;
      JAL:      state_n = tgt_mis ? TRAP : ALUWB;
      default:  state_n = TRAP;
    endcase
  end

  always_comb begin
    mem_req   = !rst && (state == FETCH || state == MEMREAD || state == MEMWRITE);
    mem_we    = !rst && state == MEMWRITE;
    mem_addr  = state == FETCH ? pc : aluout;
    mem_wdata = rs2_v;
    retire    = !rst && (state == MEMWB || state == ALUWB ||
                         (state == MEMWRITE && mem_ready) || (state == BEQ && beq_retire));
    halted    = !rst && state == TRAP;
  end

  always_ff @(posedge clk)
    if (rst) begin
      pc     <= RESET_PC;
      instr  <= '0;
      oldpc  <= '0;
      aluout <= '0;
      mdr    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == FETCH && mem_ready) begin
        instr <= mem_rdata;
        oldpc <= pc;
        pc    <= alu_y;
      end
      if (state == DECODE || state == MEMADR || state == EXECR || state == EXECI || state == JAL)
        aluout <= alu_y;
      if (state == MEMREAD && mem_ready) mdr <= mem_rdata;
      if ((state == MEMWB || state == ALUWB) && rd_i != '0)
        regs[rd_i] <= state == MEMWB ? mdr : aluout;
      if (((state == BEQ && f3 == 3'b000 && beq_take) || state == JAL) && !tgt_mis)
        pc <= aluout;
    end
endmodule

// File: tb/tb_multi_cycle_core.sv
// tb_multi_cycle_core: scoreboard bench; retire/write events queued by stimulus, checked by a monitor
module tb_multi_cycle_core;
  logic clk = 0, rst = 1, sel = 0;
  always #5 clk = ~clk;

  logic r32, r16;
  assign r32 = rst | sel;
  assign r16 = rst | !sel;

  logic        req32, we32, ret32, h32, req16, we16, ret16, h16;
  logic [31:0] addr32, wd32, pc32, addr16, wd16, pc16;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  multi_cycle_core #(.NUM_REGS(32)) dut32 (
    .clk(clk), .rst(r32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
    .mem_wdata(wd32), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc32), .retire(ret32), .halted(h32));

  multi_cycle_core #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst(r16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wd16), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc16), .retire(ret16), .halted(h16));

  logic        a_req, a_we, a_ret, a_halted;
  logic [31:0] a_addr, a_wdata, a_pc;
  assign a_req    = sel ? req16  : req32;
  assign a_we     = sel ? we16   : we32;
  assign a_addr   = sel ? addr16 : addr32;
  assign a_wdata  = sel ? wd16   : wd32;
  assign a_pc     = sel ? pc16   : pc32;
  assign a_ret    = sel ? ret16  : ret32;
  assign a_halted = sel ? h16    : h32;

  logic [31:0] mem [0:255];
  int stall_cnt, wait_rd, wait_wr;
  assign mem_ready = stall_cnt >= (a_we ? wait_wr : wait_rd);
  assign mem_rdata = mem[a_addr[9:2]];

  always @(posedge clk)
    if (rst) stall_cnt <= 0;
    else if (a_req && mem_ready) begin
      stall_cnt <= 0;
      if (a_we) mem[a_addr[9:2]] = a_wdata;
    end else if (a_req) stall_cnt <= stall_cnt + 1;

  typedef struct { int gap; logic [31:0] pc; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  ret_t exp_ret[$];
  wr_t  exp_wr[$];
  int n_chk = 0, n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_r(int g, logic [31:0] p);
    ret_t r;
    r.gap = g; r.pc = p;
    exp_ret.push_back(r);
  endtask

  task automatic exp_w(logic [31:0] a, logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  int cyc, last_ret;
  logic pc_due, prev_stall, p_we;
  logic [31:0] pc_exp, p_addr, p_wd;

  always @(negedge clk) begin
    ret_t r;
    wr_t w;
    if (rst) begin
      cyc = 0; last_ret = 0; pc_due = 0; prev_stall = 0;
    end else begin
      cyc++;
      if (pc_due) begin
        check("pc_after_retire", a_pc, pc_exp);
        pc_due = 0;
      end
      if (prev_stall && a_req) begin
        check("stall_addr", a_addr, p_addr);
        check("stall_we", {31'd0, a_we}, {31'd0, p_we});
        if (p_we) check("stall_wdata", a_wdata, p_wd);
      end
      prev_stall = a_req && !mem_ready;
      p_addr = a_addr; p_we = a_we; p_wd = a_wdata;
      if (a_ret) begin
        if (exp_ret.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_retire: got retire at cycle %0d expected none", cyc);
        end else begin
          r = exp_ret.pop_front();
          check("retire_gap", cyc - last_ret, r.gap);
          pc_exp = r.pc;
          pc_due = 1;
        end
        last_ret = cyc;
      end
      if (a_req && a_we && mem_ready) begin
        if (exp_wr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got write %h to %h expected none", a_wdata, a_addr);
        end else begin
          w = exp_wr.pop_front();
          check("write_addr", a_addr, w.addr);
          check("write_data", a_wdata, w.data);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011, OPL = 7'b0000011;

  task automatic begin_reset(logic s, int wr, int ww);
    rst = 1; sel = s; wait_rd = wr; wait_wr = ww;
    exp_ret.delete();
    exp_wr.delete();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run_to_halt(string tag, logic [31:0] exp_pc);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (a_halted && exp_ret.size() == 0 && exp_wr.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    check({tag, "_in_time"}, {31'd0, i < 3000}, 32'd1);
    check({tag, "_halted"}, {31'd0, a_halted}, 32'd1);
    check({tag, "_req_off"}, {31'd0, a_req}, 32'd0);
    check({tag, "_pc"}, a_pc, exp_pc);
    check({tag, "_retires_left"}, exp_ret.size(), 0);
    check({tag, "_writes_left"}, exp_wr.size(), 0);
  endtask

  initial begin
    // zero-wait arithmetic, memory, branch and jump program
    begin_reset(0, 0, 0);
    @(negedge clk);
    check("rst_req", {31'd0, a_req}, 32'd0);
    check("rst_we", {31'd0, a_we}, 32'd0);
    check("rst_retire", {31'd0, a_ret}, 32'd0);
    check("rst_halted", {31'd0, a_halted}, 32'd0);
    check("rst_pc", a_pc, 32'h0);
    mem[0]  = enc_i(OPI, 3'b000, 5'd1, 5'd0, 12'd5);
    mem[1]  = enc_i(OPI, 3'b000, 5'd2, 5'd0, 12'd7);
    mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
    mem[4]  = enc_s(5'd3, 5'd0, 12'h040);
    mem[5]  = enc_i(OPL, 3'b010, 5'd5, 5'd0, 12'h040);
    mem[6]  = enc_s(5'd5, 5'd0, 12'h044);
    mem[7]  = enc_s(5'd4, 5'd0, 12'h048);
    mem[8]  = enc_b(5'd1, 5'd2, 3'b000, 13'd8);
    mem[9]  = enc_j(5'd6, 21'd24);
    mem[11] = enc_i(OPI, 3'b000, 5'd0, 5'd0, 12'd9);
    mem[12] = enc_s(5'd0, 5'd0, 12'h050);
    mem[13] = enc_s(5'd6, 5'd0, 12'h04C);
    mem[15] = enc_b(5'd0, 5'd0, 3'b000, 13'h1FF0);
    exp_r(4, 32'd4);  exp_r(4, 32'd8);  exp_r(4, 32'd12); exp_r(4, 32'd16);
    exp_r(4, 32'd20); exp_r(5, 32'd24); exp_r(4, 32'd28); exp_r(4, 32'd32);
    exp_r(3, 32'd36); exp_r(4, 32'd60); exp_r(3, 32'd44); exp_r(4, 32'd48);
    exp_r(4, 32'd52); exp_r(4, 32'd56);
    exp_w(32'h40, 32'd12); exp_w(32'h44, 32'd12); exp_w(32'h48, 32'hFFFF_FFFE);
    exp_w(32'h50, 32'd0);  exp_w(32'h4C, 32'd40);
    release_reset();
    run_to_halt("prog", 32'd60);

    // three wait states on every transaction
    begin_reset(0, 3, 3);
    mem[0]  = enc_i(OPL, 3'b010, 5'd5, 5'd0, 12'h040);
    mem[1]  = enc_s(5'd5, 5'd0, 12'h044);
    mem[16] = 32'h1234_5678;
    exp_r(11, 32'd4); exp_r(10, 32'd8);
    exp_w(32'h44, 32'h1234_5678);
    release_reset();
    run_to_halt("wait", 32'd12);

    // misaligned load address
    begin_reset(0, 0, 0);
    mem[0] = enc_i(OPL, 3'b010, 5'd5, 5'd0, 12'h041);
    release_reset();
    run_to_halt("lw_mis", 32'd4);

    // misaligned taken branch target leaves pc alone
    begin_reset(0, 0, 0);
    mem[0] = enc_b(5'd0, 5'd0, 3'b000, 13'd6);
    release_reset();
    run_to_halt("beq_mis", 32'd4);

    // RV32E rejects x20
    begin_reset(1, 0, 0);
    mem[0] = enc_i(OPI, 3'b000, 5'd1, 5'd0, 12'd3);
    mem[1] = enc_s(5'd1, 5'd0, 12'h040);
    mem[2] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd20);
    exp_r(4, 32'd4); exp_r(4, 32'd8);
    exp_w(32'h40, 32'd3);
    release_reset();
    run_to_halt("rv32e", 32'd12);

    // reset during a stalled store
    begin_reset(0, 0, 1000);
    mem[0] = enc_s(5'd0, 5'd0, 12'h040);
    release_reset();
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(negedge clk);
        if (a_req && a_we) break;
      end
      check("reach_memwrite", {31'd0, a_we}, 32'd1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    check("rst_mid_req", {31'd0, a_req}, 32'd0);
    check("rst_mid_pc_before_edge", a_pc, 32'd4);
    @(posedge clk);
    #1;
    check("rst_mid_pc", a_pc, 32'd0);
    wait_wr = 0;
    exp_r(4, 32'd4);
    exp_w(32'h40, 32'd0);
    rst = 0;
    #1;
    check("refetch_req", {31'd0, a_req}, 32'd1);
    check("refetch_addr", a_addr, 32'd0);
    check("refetch_we", {31'd0, a_we}, 32'd0);
    run_to_halt("restart", 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
